multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Sequencing controller for the multi-cycle RV32I datapath. Walks each instruction through
//  FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes (IR/PC/regfile write, memory
//  request, ALU and writeback selects). Handshakes with the shared instruction/data memory
//  port, traps on illegal opcodes or memory timeout, and counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_ready per request; 0 = wait forever
//  CNT_W        32  width of instret counter
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  rst           in   1      asynchronous, active-high reset
//  opcode        in   7      IR[6:0], valid from DECODE onward
//  branch_taken  in   1      ALU compare result, sampled in EXEC of a branch
//  mem_ready     in   1      memory completes current request this cycle
//  mem_req       out  1      memory request, held until mem_ready
//  mem_we        out  1      1 = store request (valid only with mem_req)
//  ir_write      out  1      latch fetched word into IR
//  pc_write      out  1      update PC this cycle
//  pc_src        out  2      00 PC+4, 01 PC+imm, 10 ALU result (jalr, LSB cleared by datapath)
//  alu_op        out  2      00 add, 01 branch compare, 10 funct-decoded
//  alu_src_b     out  1      0 = rs2, 1 = immediate
//  reg_write     out  1      regfile write enable
//  wb_sel        out  2      00 ALU, 01 load data, 10 PC+4
//  trap          out  1      sticky fault flag
//  instret       out  CNT_W  retired instruction count
//  state_o       out  3      current state encoding, for debug
// BEHAVIOUR
//  - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. state, timeout counter, instret
//    and trap are registered; strobes are combinational from state (+ mem_ready, branch_taken).
//  - Reset: state=FETCH, instret=0, trap=0, timeout counter=0. While rst=1, force all
//    strobes (mem_req, ir_write, pc_write, reg_write) to 0 and all selects to 0.
//  - FETCH: mem_req=1, mem_we=0. When mem_ready=1: ir_write=1 in the same cycle, next state
//    DECODE.
//  - DECODE: no strobes. Legal opcodes: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE,
//    1100011 BRANCH, 1101111 JAL, 1100111 JALR. Legal -> EXEC; any other opcode -> TRAP.
//  - EXEC: alu_src_b=0 for R/BRANCH, else 1.
//    - alu_op=10 for R/I, 01 for BRANCH, 00 otherwise.
//    - BRANCH: pc_write=1, pc_src=branch_taken?01:00, instret++, next state FETCH.
//    - LOAD/STORE -> MEM. R/I/JAL/JALR -> WB.
//  - MEM: mem_req=1, mem_we=(STORE), alu_op=00, alu_src_b=1. On mem_ready:
//    - STORE: pc_write=1, pc_src=00, instret++, next state FETCH.
//    - LOAD: next state WB. Load data is latched by the datapath on the same cycle.
//  - WB: reg_write=1, instret++, next state FETCH. pc_write=1.
//    - wb_sel: 01 LOAD, 10 JAL/JALR, 00 otherwise.
//    - pc_src: 01 JAL, 10 JALR, 00 otherwise.
//  - Latency: BRANCH = 3 cycles; R/I/JAL/JALR/STORE = 4 cycles; LOAD = 5 cycles. This
//    assumes 0-wait memory (mem_ready=1 in the first request cycle). Each wait cycle adds 1.
//  - Timeout: the counter clears on entry to FETCH/MEM and on mem_ready, and increments
//    each cycle mem_req=1 && mem_ready=0. With MEM_TIMEOUT!=0, if the counter reaches
//    MEM_TIMEOUT-1 while still not ready, the next state is TRAP. mem_ready in that same
//    cycle wins (normal completion).
//  - TRAP: trap=1 (sticky); all strobes 0; remain in TRAP until rst. instret frozen.
//  - instret wraps from 2^CNT_W-1 to 0 with no flag.
//  - Reset mid-operation: asynchronous return to FETCH, in-flight memory request dropped;
//    memory must tolerate mem_req falling without ready.
//  - mem_ready outside FETCH/MEM is ignored.
// TESTING
//  - R-type 0x00B50533, mem_ready always 1:
//    -> states 0,1,2,4,0; reg_write=1 only in WB, wb_sel=00; instret 0->1.
//  - LOAD opcode 0000011, mem_ready delayed 2 cycles in MEM:
//    -> mem_req,mem_we=1,0 held 3 cycles; WB with wb_sel=01; total 7 cycles.
//  - BRANCH:
//    -> branch_taken=1: pc_src=01 in EXEC, back to FETCH after 3 cycles.
//    -> repeat with taken=0: pc_src=00.
//  - Illegal opcode 0000000:
//    -> DECODE->TRAP; trap=1 and all strobes 0 for 20 further cycles; rst clears to FETCH.
//  - MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP entered after exactly 4 request cycles.
//  - CNT_W=4, 16 back-to-back JAL -> instret wraps to 0; rst asserted mid-MEM
//    -> state_o=0 and mem_req=0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - sequencing controller for the multi-cycle RV32I datapath
// Walks FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes, traps on bad opcode or memory timeout.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src_b,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam int TO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            r_state;
  state_t            w_next;
  logic [TO_W-1:0]   r_to_cnt;
  logic [CNT_W-1:0]  r_instret;
  logic              r_trap;
  logic              w_inc;
  logic              w_timeout;

  logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_br, w_is_jal, w_is_jalr, w_legal;

  assign w_is_r     = (opcode == 7'b0110011);
  assign w_is_i     = (opcode == 7'b0010011);
  assign w_is_load  = (opcode == 7'b0000011);
  assign w_is_store = (opcode == 7'b0100011);
  assign w_is_br    = (opcode == 7'b1100011);
  assign w_is_jal   = (opcode == 7'b1101111);
  assign w_is_jalr  = (opcode == 7'b1100111);
  assign w_legal    = w_is_r | w_is_i | w_is_load | w_is_store | w_is_br | w_is_jal | w_is_jalr;

  // A ready arriving on the last allowed cycle still completes the request.
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_to_cnt == TO_LIMIT) && !mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_to_cnt  <= '0;
      r_instret <= '0;
      r_trap    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP)
        r_trap <= 1'b1;
      if (w_inc)
        r_instret <= r_instret + CNT_W'(1);
      if (mem_ready || ((w_next != r_state) && (w_next == S_FETCH || w_next == S_MEM)))
        r_to_cnt <= '0;
      else if (mem_req)
        r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_inc     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    alu_op    = 2'b00;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alu_src_b = !(w_is_r || w_is_br);
        alu_op    = (w_is_r || w_is_i) ? 2'b10 : (w_is_br ? 2'b01 : 2'b00);
        if (w_is_br) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? 2'b01 : 2'b00;
          w_inc    = 1'b1;
          w_next   = S_FETCH;
        end else if (w_is_load || w_is_store) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = w_is_store;
        alu_src_b = 1'b1;
        if (mem_ready) begin
          if (w_is_store) begin
            pc_write = 1'b1;
            w_inc    = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        w_inc     = 1'b1;
        wb_sel    = w_is_load ? 2'b01 : ((w_is_jal || w_is_jalr) ? 2'b10 : 2'b00);
        pc_src    = w_is_jal ? 2'b01 : (w_is_jalr ? 2'b10 : 2'b00);
        w_next    = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
    // Reset state is FETCH, so strobes must be masked explicitly while rst is held.
    if (rst) begin
      w_inc     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      alu_op    = 2'b00;
      alu_src_b = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
    end
  end

  assign trap    = r_trap;
  assign instret = r_instret;
  assign state_o = r_state;

endmodule
